// File: rtl/rx_mtr_sweep_ctrl.sv
// Sweep sequencer for the meander test generator / ADC receiver chain: steps M
// from m_start to m_end, measures RXP/RXN rising edges and AMP per step.
module rx_mtr_sweep_ctrl #(
  parameter int M_W    = 6,
  parameter int AMP_W  = 11,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 4000,
  parameter int WIN    = 16384
) (
  input  logic             clk,
  input  logic             res,
  input  logic             go,
  input  logic             abort,
  input  logic [M_W-1:0]   m_start,
  input  logic [M_W-1:0]   m_end,
  input  logic             s_en,
  output logic             st,
  output logic [M_W-1:0]   M,
  output logic             S,
  output logic             rx_res,
  input  logic             RXP,
  input  logic             RXN,
  input  logic [AMP_W-1:0] AMP,
  output logic             busy,
  output logic             done,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [M_W-1:0]   r_m,
  output logic [AMP_W-1:0] r_amp,
  output logic [CNT_W-1:0] r_np,
  output logic [CNT_W-1:0] r_nn
);

  localparam int TMAX  = (SETTLE > WIN) ? SETTLE : WIN;
  localparam int TMR_W = $clog2(TMAX);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_SETTLE, ST_MEAS, ST_REPORT} state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [M_W-1:0]   m_last;
  logic             dir_up;
  logic             p_prev, n_prev;
  logic [CNT_W-1:0] cnt_p, cnt_n, cnt_p_nxt, cnt_n_nxt;
  logic             accept, abort_now, tmr_zero, handshake, at_end;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_nxt = state;
    st        = 1'b0;
    rx_res    = 1'b0;
    accept    = go && !abort;
    abort_now = abort && (state != ST_IDLE);
    tmr_zero  = (tmr == '0);
    handshake = r_valid && r_ready;
    at_end    = (M == m_last);
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_START;
      ST_START: begin
        st        = 1'b1;
        rx_res    = 1'b1;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: if (tmr_zero) state_nxt = ST_MEAS;
      ST_MEAS:   if (tmr_zero) state_nxt = ST_REPORT;
      ST_REPORT: if (handshake) state_nxt = at_end ? ST_IDLE : ST_START;
      default:   state_nxt = ST_IDLE;
    endcase
    if (abort_now) state_nxt = ST_IDLE;
  end

  // Edge counters saturate at all-ones; an edge on the current cycle is included.
  always_comb begin
    cnt_p_nxt = cnt_p;
    cnt_n_nxt = cnt_n;
    if (RXP && !p_prev && (cnt_p != '1)) cnt_p_nxt = cnt_p + CNT_W'(1);
    if (RXN && !n_prev && (cnt_n != '1)) cnt_n_nxt = cnt_n + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge res) begin
    if (res) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      tmr     <= '0;
      m_last  <= '0;
      dir_up  <= 1'b0;
      p_prev  <= 1'b0;
      n_prev  <= 1'b0;
      cnt_p   <= '0;
      cnt_n   <= '0;
      M       <= '0;
      S       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      r_valid <= 1'b0;
      r_m     <= '0;
      r_amp   <= '0;
      r_np    <= '0;
      r_nn    <= '0;
    end else begin
      done   <= 1'b0;
      p_prev <= RXP;
      n_prev <= RXN;
      if (abort_now) begin
        r_valid <= 1'b0;
        busy    <= 1'b0;
        S       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (accept) begin
            m_last <= m_end;
            dir_up <= (m_start <= m_end);
            M      <= m_start;
            S      <= s_en;
            busy   <= 1'b1;
          end
          ST_START: tmr <= TMR_W'(SETTLE - 1);
          ST_SETTLE: begin
            if (tmr_zero) begin
              cnt_p <= '0;
              cnt_n <= '0;
              tmr   <= TMR_W'(WIN - 1);
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
          ST_MEAS: begin
            cnt_p <= cnt_p_nxt;
            cnt_n <= cnt_n_nxt;
            if (tmr_zero) begin
              r_amp   <= AMP;
              r_np    <= cnt_p_nxt;
              r_nn    <= cnt_n_nxt;
              r_m     <= M;
              r_valid <= 1'b1;
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
          ST_REPORT: if (handshake) begin
            r_valid <= 1'b0;
            if (at_end) begin
              done <= 1'b1;
              busy <= 1'b0;
              S    <= 1'b0;
            end else begin
              M <= dir_up ? M + M_W'(1) : M - M_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_mtr_sweep_ctrl.sv
// Self-checking bench for rx_mtr_sweep_ctrl: randomized RXP/RXN/AMP, results
// predicted from logged inputs over the measurement window relative to each st.
module tb_rx_mtr_sweep_ctrl;

  localparam int M_W    = 6;
  localparam int AMP_W  = 11;
  localparam int CNT_W  = 4;
  localparam int SETTLE = 4;
  localparam int WIN    = 32;
  localparam int LAT    = 1 + SETTLE + WIN;
  localparam int SAT    = (1 << CNT_W) - 1;
  localparam int LOGN   = 32768;

  logic             clk = 1'b0;
  logic             res, go, abort, s_en, RXP, RXN, r_ready;
  logic [M_W-1:0]   m_start, m_end, M, r_m;
  logic [AMP_W-1:0] AMP, r_amp;
  logic             st, S, rx_res, busy, done, r_valid;
  logic [CNT_W-1:0] r_np, r_nn;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ph       = 0;
  int last_np, last_nn;

  logic             rxp_log[LOGN];
  logic             rxn_log[LOGN];
  logic [AMP_W-1:0] amp_log[LOGN];

  rx_mtr_sweep_ctrl #(
    .M_W(M_W), .AMP_W(AMP_W), .CNT_W(CNT_W), .SETTLE(SETTLE), .WIN(WIN)
  ) dut (
    .clk(clk), .res(res), .go(go), .abort(abort),
    .m_start(m_start), .m_end(m_end), .s_en(s_en),
    .st(st), .M(M), .S(S), .rx_res(rx_res),
    .RXP(RXP), .RXN(RXN), .AMP(AMP),
    .busy(busy), .done(done),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_m(r_m), .r_amp(r_amp), .r_np(r_np), .r_nn(r_nn)
  );

  always #5 clk = ~clk;

  // Log what the DUT sees at each rising edge, indexed by edge number.
  always @(posedge clk) begin
    cyc = cyc + 1;
    rxp_log[cyc % LOGN] = RXP;
    rxn_log[cyc % LOGN] = RXN;
    amp_log[cyc % LOGN] = AMP;
  end

  // Mode 0: random, 1: RXP toggles every 4 cycles, 2: RXP toggles every cycle.
  task automatic drive_rx(input int mode);
    ph = ph + 1;
    case (mode)
      1: begin RXP = ((ph / 4) % 2) == 1; RXN = 1'b0; end
      2: begin RXP = (ph % 2) == 1; RXN = 1'($urandom_range(0, 1)); end
      default: begin RXP = 1'($urandom_range(0, 1)); RXN = 1'($urandom_range(0, 1)); end
    endcase
    AMP = AMP_W'($urandom);
  endtask

  // Rising edges over the WIN edges ending at edge 'last', saturated.
  function automatic int count_edges(input bit pos, input int last);
    int   n;
    logic c, p;
    n = 0;
    for (int e = last - WIN + 1; e <= last; e++) begin
      c = pos ? rxp_log[e % LOGN] : rxn_log[e % LOGN];
      p = pos ? rxp_log[(e - 1) % LOGN] : rxn_log[(e - 1) % LOGN];
      if (c && !p) n++;
    end
    return (n > SAT) ? SAT : n;
  endfunction

  function automatic logic [47:0] out_vec();
    return 48'({st, M, S, rx_res, busy, done, r_valid, r_m, r_amp, r_np, r_nn});
  endfunction

  task automatic run_sweep(input int ms, input int me, input bit s, input int stall,
                           input int mode, input bit hold_go, input string tag);
    int dir, n_steps, steps_done, st_cnt, st_at, prev_st, stall_left, exp_m, exp_np, exp_nn;
    bit in_rep, done_due, finished, hs_prev;
    logic [M_W-1:0]   snap_m;
    logic [AMP_W-1:0] snap_amp;
    logic [CNT_W-1:0] snap_np, snap_nn;
    dir        = (ms <= me) ? 1 : -1;
    n_steps    = (ms <= me) ? (me - ms + 1) : (ms - me + 1);
    steps_done = 0; st_cnt = 0; st_at = -1; prev_st = -1;
    stall_left = stall; exp_m = ms;
    in_rep = 0; done_due = 0; finished = 0; hs_prev = 0;
    @(negedge clk);
    drive_rx(mode);
    go = 1'b1; m_start = M_W'(ms); m_end = M_W'(me); s_en = s; r_ready = 1'b1;
    for (int b = 0; b < 600 && !finished; b++) begin
      @(negedge clk);
      if (!hold_go) go = 1'b0;
      if (done_due) begin
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || S !== 1'b0 || r_valid !== 1'b0 || M !== M_W'(me)) begin
          n_fail++;
          $display("FAIL %s done_end: done=%b busy=%b S=%b r_valid=%b M=%0d, expected 1 0 0 0 M=%0d",
                   tag, done, busy, S, r_valid, M, me);
        end
        finished = 1;
      end else begin
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1 || S !== s) begin
          n_fail++;
          $display("FAIL %s busy_s: done=%b busy=%b S=%b, expected done=0 busy=1 S=%b",
                   tag, done, busy, S, s);
        end
        if (hs_prev) begin
          n_checks++;
          if (r_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s valid_drop: r_valid=%b after handshake, expected 0", tag, r_valid);
          end
        end
        hs_prev = 0;
        if (st === 1'b1) begin
          n_checks++;
          if (M !== M_W'(exp_m) || rx_res !== 1'b1 || st_cnt >= n_steps) begin
            n_fail++;
            $display("FAIL %s st_m: M=%0d rx_res=%b st#%0d, expected M=%0d rx_res=1 within %0d steps",
                     tag, M, rx_res, st_cnt + 1, exp_m, n_steps);
          end
          if (prev_st >= 0) begin
            n_checks++;
            if (cyc - prev_st != LAT + 1 + stall) begin
              n_fail++;
              $display("FAIL %s st_gap: %0d cycles, expected %0d", tag, cyc - prev_st, LAT + 1 + stall);
            end
          end
          prev_st = cyc; st_at = cyc; st_cnt++; stall_left = stall;
        end else if (rx_res !== 1'b0) begin
          n_checks++; n_fail++;
          $display("FAIL %s rx_res: rx_res=%b without st, expected 0", tag, rx_res);
        end
        if (r_valid === 1'b1) begin
          if (!in_rep) begin
            in_rep = 1;
            n_checks++;
            if (cyc - st_at != LAT) begin
              n_fail++;
              $display("FAIL %s latency: r_valid %0d cycles after st, expected %0d", tag, cyc - st_at, LAT);
            end
            exp_np = count_edges(1'b1, cyc);
            exp_nn = count_edges(1'b0, cyc);
            n_checks++;
            if (r_m !== M_W'(exp_m) || r_np !== CNT_W'(exp_np) || r_nn !== CNT_W'(exp_nn)
                || r_amp !== amp_log[cyc % LOGN]) begin
              n_fail++;
              $display("FAIL %s result: r_m=%0d r_np=%0d r_nn=%0d r_amp=%0d, expected %0d %0d %0d %0d",
                       tag, r_m, r_np, r_nn, r_amp, exp_m, exp_np, exp_nn, amp_log[cyc % LOGN]);
            end
            snap_m = r_m; snap_amp = r_amp; snap_np = r_np; snap_nn = r_nn;
            last_np = exp_np; last_nn = exp_nn;
          end else begin
            n_checks++;
            if (r_m !== snap_m || r_amp !== snap_amp || r_np !== snap_np || r_nn !== snap_nn) begin
              n_fail++;
              $display("FAIL %s stable: r_m=%0d r_amp=%0d r_np=%0d r_nn=%0d, expected %0d %0d %0d %0d",
                       tag, r_m, r_amp, r_np, r_nn, snap_m, snap_amp, snap_np, snap_nn);
            end
          end
        end
        drive_rx(mode);
        if (r_valid === 1'b1 && stall_left > 0) begin
          r_ready = 1'b0; stall_left--;
        end else begin
          r_ready = 1'b1;
        end
        if (r_valid === 1'b1 && r_ready) begin
          in_rep = 0; hs_prev = 1; steps_done++; exp_m = exp_m + dir;
          if (steps_done == n_steps) begin done_due = 1; go = 1'b0; end
        end
      end
    end
    go = 1'b0;
    n_checks++;
    if (!finished || st_cnt != n_steps) begin
      n_fail++;
      $display("FAIL %s completion: finished=%0d st pulses=%0d, expected 1 and %0d", tag, finished, st_cnt, n_steps);
    end
    repeat (5) begin
      @(negedge clk);
      drive_rx(mode);
      n_checks++;
      if (st !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || r_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle_after: st=%b busy=%b done=%b r_valid=%b, expected all 0", tag, st, busy, done, r_valid);
      end
    end
  endtask

  task automatic test_reset;
    res = 1'b1; go = 1'b0; abort = 1'b0; s_en = 1'b0; r_ready = 1'b0;
    m_start = '0; m_end = '0; RXP = 1'b0; RXN = 1'b0; AMP = '0;
    #1;
    n_checks++;
    if (out_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_async: outputs=%h, expected 0", out_vec());
    end
    repeat (3) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_release: outputs=%h, expected 0", out_vec());
    end
  endtask

  task automatic test_single;
    run_sweep(6, 6, 1'b1, 0, 1, 1'b0, "single");
    n_checks++;
    if (last_np != 4 || last_nn != 0) begin
      n_fail++;
      $display("FAIL single_counts: np=%0d nn=%0d, expected 4 0", last_np, last_nn);
    end
  endtask

  task automatic test_up_down;
    run_sweep(4, 6, 1'b0, 0, 0, 1'b0, "up");
    run_sweep(6, 4, 1'b1, 0, 0, 1'b0, "down");
  endtask

  task automatic test_backpressure;
    run_sweep(7, 8, 1'b1, 10, 0, 1'b0, "stall");
  endtask

  task automatic test_saturation;
    run_sweep(5, 5, 1'b0, 0, 2, 1'b0, "sat");
    n_checks++;
    if (last_np != SAT) begin
      n_fail++;
      $display("FAIL sat_np: np=%0d, expected %0d", last_np, SAT);
    end
  endtask

  task automatic test_abort;
    int seen;
    @(negedge clk);
    drive_rx(0);
    go = 1'b1; m_start = 6'd4; m_end = 6'd6; s_en = 1'b1; r_ready = 1'b1;
    seen = 0;
    for (int b = 0; b < 300 && seen < 2; b++) begin
      @(negedge clk);
      go = 1'b0;
      if (st === 1'b1) seen++;
      drive_rx(0);
    end
    n_checks++;
    if (seen != 2) begin
      n_fail++;
      $display("FAIL abort_reach: saw %0d st pulses, expected 2", seen);
    end
    repeat (SETTLE + 6) begin @(negedge clk); drive_rx(0); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || r_valid !== 1'b0 || st !== 1'b0 || S !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b r_valid=%b st=%b S=%b done=%b, expected all 0",
               busy, r_valid, st, S, done);
    end
    for (int b = 0; b < 60; b++) begin
      @(negedge clk);
      drive_rx(0);
      if (b == 0) begin
        // abort held in IDLE together with go must not start a sweep
        abort = 1'b1; go = 1'b1;
      end else begin
        abort = 1'b0; go = 1'b0;
      end
      n_checks++;
      if (busy !== 1'b0 || r_valid !== 1'b0 || st !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet: busy=%b r_valid=%b st=%b done=%b at %0d, expected all 0",
                 busy, r_valid, st, done, b);
      end
    end
    run_sweep(10, 9, 1'b1, 0, 0, 1'b0, "restart");
  endtask

  task automatic test_res_mid;
    int seen;
    @(negedge clk);
    drive_rx(0);
    go = 1'b1; m_start = 6'd20; m_end = 6'd22; s_en = 1'b1; r_ready = 1'b1;
    seen = 0;
    for (int b = 0; b < 10 && seen == 0; b++) begin
      @(negedge clk);
      go = 1'b0;
      if (st === 1'b1) seen = 1;
    end
    @(negedge clk);
    @(negedge clk);
    res = 1'b1;
    #1;
    n_checks++;
    if (seen != 1 || out_vec() !== '0) begin
      n_fail++;
      $display("FAIL res_mid: st_seen=%0d outputs=%h, expected 1 and 0", seen, out_vec());
    end
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_vec() !== '0) begin
      n_fail++;
      $display("FAIL res_after: outputs=%h, expected 0", out_vec());
    end
    run_sweep(3, 5, 1'b1, 0, 0, 1'b1, "hold_go");
  endtask

  initial begin
    test_reset();
    test_single();
    test_up_down();
    test_backpressure();
    test_saturation();
    test_abort();
    test_res_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
